// File: rtl/dec_width_pkg.sv
// Definitions shared by the decoder-path width converters (upsizer and downsizer):
// FSM state encoding and an elaboration-time clog2.
package dec_width_pkg;

    localparam logic STATE_ACCUM_ENC = 1'b0;
    localparam logic STATE_HOLD_ENC  = 1'b1;

    typedef enum logic {
        ACCUM = STATE_ACCUM_ENC,
        HOLD  = STATE_HOLD_ENC
    } convState_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/dec_width_out_reg.sv
// Output holding register (valid/data/last, plus keep when DEC_UPSIZE_KEEP_EN is defined)
// for the decoder width converters. A load wins over a drain; a drain alone only clears valid.
module dec_width_out_reg #(
    parameter int DATA_W = 32
`ifdef DEC_UPSIZE_KEEP_EN
    ,
    parameter int KEEP_W = 2
`endif
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iLoad,
    input  logic [DATA_W-1:0] iLoadData,
    input  logic              iLoadLast,
`ifdef DEC_UPSIZE_KEEP_EN
    input  logic [KEEP_W-1:0] iLoadKeep,
    output logic [KEEP_W-1:0] oKeep,
`endif
    input  logic              iDstReady,
    output logic              oValid,
    output logic [DATA_W-1:0] oData,
    output logic              oLast,
    output logic              oFree
);

    assign oFree = ~oValid | iDstReady;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            // NOTE: data is reset as well, so the port reads 0 rather than a stale word after reset.
            oValid <= 1'b0;
            oData  <= '0;
            oLast  <= 1'b0;
`ifdef DEC_UPSIZE_KEEP_EN
            oKeep  <= '0;
`endif
        end else if (iLoad) begin
            oValid <= 1'b1;
            oData  <= iLoadData;
            oLast  <= iLoadLast;
`ifdef DEC_UPSIZE_KEEP_EN
            oKeep  <= iLoadKeep;
`endif
        end else if (iDstReady) begin
            oValid <= 1'b0;
        end
    end

endmodule

// File: rtl/dec_width_upsizer.sv
// N:1 beat packer between the ECC decoder and wide DMA/buffer ports; first beat lands in the
// most-significant lane. Defining DEC_UPSIZE_KEEP_EN adds the oConvertedKeep lane mask.
module dec_width_upsizer
    import dec_width_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int RATIO = 2
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iSrcDataValid,
    input  logic [IN_W-1:0]       iSrcData,
    input  logic                  iSrcDataLast,
    output logic                  oConverterReady,
    output logic                  oConvertedDataValid,
    output logic [IN_W*RATIO-1:0] oConvertedData,
    output logic                  oConvertedDataLast,
`ifdef DEC_UPSIZE_KEEP_EN
    output logic [RATIO-1:0]      oConvertedKeep,
`endif
    input  logic                  iDstReady
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    convState_t       state;
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] accMerged;
    logic             accLast;
    logic             accept;
    logic             complete;
    logic             drain;
    logic             outFree;
    logic             loadOut;
    logic [OUT_W-1:0] loadData;
    logic             loadLast;
`ifdef DEC_UPSIZE_KEEP_EN
    logic [RATIO-1:0] accKeep;
    logic [RATIO-1:0] keepMerged;
    logic [RATIO-1:0] loadKeep;
`endif

    assign accept   = iSrcDataValid & oConverterReady;
    assign complete = accept & ((count == LAST_CNT) | iSrcDataLast);
    assign drain    = oConvertedDataValid & iDstReady;

    // Beat k goes to lane RATIO-1-k, so the first beat ends up in the top bits.
    always_comb begin
        // NOTE: default assignment first so the partial lane write cannot infer a latch.
        accMerged = acc;
        for (int lane = 0; lane < RATIO; lane++) begin
            if (int'(count) == RATIO - 1 - lane) begin
                accMerged[lane*IN_W +: IN_W] = iSrcData;
            end
        end
    end

`ifdef DEC_UPSIZE_KEEP_EN
    always_comb begin
        keepMerged = accKeep;
        for (int lane = 0; lane < RATIO; lane++) begin
            if (int'(count) == RATIO - 1 - lane) begin
                keepMerged[lane] = 1'b1;
            end
        end
    end
`endif

    // HOLD releases the parked word; ACCUM forwards the just-completed word directly.
    always_comb begin
        loadOut  = 1'b0;
        loadData = accMerged;
        loadLast = iSrcDataLast;
`ifdef DEC_UPSIZE_KEEP_EN
        loadKeep = keepMerged;
`endif
        if (state == HOLD) begin
            loadOut  = drain;
            loadData = acc;
            loadLast = accLast;
`ifdef DEC_UPSIZE_KEEP_EN
            loadKeep = accKeep;
`endif
        end else begin
            loadOut = complete & outFree;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state           <= ACCUM;
            oConverterReady <= 1'b1;
            count           <= '0;
            acc             <= '0;
            accLast         <= 1'b0;
`ifdef DEC_UPSIZE_KEEP_EN
            accKeep         <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (complete) begin
                        count <= '0;
                        if (outFree) begin
                            acc     <= '0;
                            accLast <= 1'b0;
`ifdef DEC_UPSIZE_KEEP_EN
                            accKeep <= '0;
`endif
                        end else begin
                            acc             <= accMerged;
                            accLast         <= iSrcDataLast;
`ifdef DEC_UPSIZE_KEEP_EN
                            accKeep         <= keepMerged;
`endif
                            state           <= HOLD;
                            oConverterReady <= 1'b0;
                        end
                    end else if (accept) begin
                        acc   <= accMerged;
                        count <= count + 1'b1;
`ifdef DEC_UPSIZE_KEEP_EN
                        accKeep <= keepMerged;
`endif
                    end
                end
                HOLD: begin
                    if (drain) begin
                        acc             <= '0;
                        accLast         <= 1'b0;
`ifdef DEC_UPSIZE_KEEP_EN
                        accKeep         <= '0;
`endif
                        state           <= ACCUM;
                        oConverterReady <= 1'b1;
                    end
                end
            endcase
        end
    end

    dec_width_out_reg #(
        .DATA_W (OUT_W)
`ifdef DEC_UPSIZE_KEEP_EN
        ,
        .KEEP_W (RATIO)
`endif
    ) uOutReg (
        .iClock    (iClock),
        .iReset    (iReset),
        .iLoad     (loadOut),
        .iLoadData (loadData),
        .iLoadLast (loadLast),
`ifdef DEC_UPSIZE_KEEP_EN
        .iLoadKeep (loadKeep),
        .oKeep     (oConvertedKeep),
`endif
        .iDstReady (iDstReady),
        .oValid    (oConvertedDataValid),
        .oData     (oConvertedData),
        .oLast     (oConvertedDataLast),
        .oFree     (outFree)
    );

endmodule

// File: tb/tb_dec_width_upsizer.sv
// Bench for dec_width_upsizer: three configurations (16x2, 16x4, 8x8) against a packing scoreboard.
// Keep checks are compiled in when DEC_UPSIZE_KEEP_EN is defined.
module tb_dec_width_upsizer;

    logic iClock = 1'b0;
    logic iReset;
    always #5 iClock = ~iClock;

    logic        v2, l2, r2, ov2, ol2, dr2;
    logic [15:0] d2;
    logic [31:0] od2;
    logic        v4, l4, r4, ov4, ol4, dr4;
    logic [15:0] d4;
    logic [63:0] od4;
    logic        v8, l8, r8, ov8, ol8, dr8;
    logic [7:0]  d8;
    logic [63:0] od8;
`ifdef DEC_UPSIZE_KEEP_EN
    logic [1:0]  ok2;
    logic [3:0]  ok4;
    logic [7:0]  ok8;
`endif

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [7:0]  keep;
    } word_t;

    word_t       q2[$];
    word_t       q4[$];
    word_t       q8[$];
    logic [63:0] mAcc[3];
    logic [7:0]  mKeep[3];
    int          mCnt[3];
    int          pushed8 = 0;
    int          words8 = 0;
    int          checks = 0;
    int          errors = 0;
    int          stalls;

    dec_width_upsizer #(.IN_W(16), .RATIO(2)) u2 (
        .iClock(iClock), .iReset(iReset), .iSrcDataValid(v2), .iSrcData(d2), .iSrcDataLast(l2),
        .oConverterReady(r2), .oConvertedDataValid(ov2), .oConvertedData(od2),
        .oConvertedDataLast(ol2),
`ifdef DEC_UPSIZE_KEEP_EN
        .oConvertedKeep(ok2),
`endif
        .iDstReady(dr2));

    dec_width_upsizer #(.IN_W(16), .RATIO(4)) u4 (
        .iClock(iClock), .iReset(iReset), .iSrcDataValid(v4), .iSrcData(d4), .iSrcDataLast(l4),
        .oConverterReady(r4), .oConvertedDataValid(ov4), .oConvertedData(od4),
        .oConvertedDataLast(ol4),
`ifdef DEC_UPSIZE_KEEP_EN
        .oConvertedKeep(ok4),
`endif
        .iDstReady(dr4));

    dec_width_upsizer #(.IN_W(8), .RATIO(8)) u8 (
        .iClock(iClock), .iReset(iReset), .iSrcDataValid(v8), .iSrcData(d8), .iSrcDataLast(l8),
        .oConverterReady(r8), .oConvertedDataValid(ov8), .oConvertedData(od8),
        .oConvertedDataLast(ol8),
`ifdef DEC_UPSIZE_KEEP_EN
        .oConvertedKeep(ok8),
`endif
        .iDstReady(dr8));

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic readyOf(input int sel);
        case (sel)
            0:       return r2;
            1:       return r4;
            default: return r8;
        endcase
    endfunction

    task automatic driveSrc(input int sel, input logic valid, input logic [15:0] data, input logic last);
        case (sel)
            0:       begin v2 = valid; d2 = data;      l2 = last; end
            1:       begin v4 = valid; d4 = data;      l4 = last; end
            default: begin v8 = valid; d8 = data[7:0]; l8 = last; end
        endcase
    endtask

    task automatic clearModels();
        for (int s = 0; s < 3; s++) begin
            mAcc[s]  = '0;
            mKeep[s] = '0;
            mCnt[s]  = 0;
        end
        q2.delete();
        q4.delete();
        q8.delete();
    endtask

    // Reference packing: beat k of a word lands in lane RATIO-1-k.
    task automatic modelBeat(input int sel, input logic [15:0] data, input logic last);
        int    inW;
        int    ratio;
        int    lane;
        word_t w;
        inW   = (sel == 2) ? 8 : 16;
        ratio = (sel == 0) ? 2 : ((sel == 1) ? 4 : 8);
        lane  = ratio - 1 - mCnt[sel];
        mAcc[sel]        = mAcc[sel] | ((64'(data) & ((64'd1 << inW) - 64'd1)) << (lane * inW));
        mKeep[sel][lane] = 1'b1;
        if (mCnt[sel] == ratio - 1 || last) begin
            w.data = mAcc[sel];
            w.last = last;
            w.keep = mKeep[sel];
            case (sel)
                0:       q2.push_back(w);
                1:       q4.push_back(w);
                default: begin q8.push_back(w); pushed8++; end
            endcase
            mAcc[sel]  = '0;
            mKeep[sel] = '0;
            mCnt[sel]  = 0;
        end else begin
            mCnt[sel]++;
        end
    endtask

    // Entered #1 after a rising edge; returns #1 after the edge that took the beat.
    task automatic sendBeat(input int sel, input logic [15:0] data, input logic last,
                            input bit randReady, output int nStall);
        nStall = 0;
        driveSrc(sel, 1'b1, data, last);
        forever begin
            if (randReady) dr8 = 1'($urandom_range(0, 1));
            @(negedge iClock);
            if (readyOf(sel)) break;
            nStall++;
            if (nStall > 100) begin
                check("accept_timeout", 64'(nStall), 64'd100);
                break;
            end
            @(posedge iClock);
            #1;
        end
        if (nStall <= 100) modelBeat(sel, data, last);
        @(posedge iClock);
        #1;
        driveSrc(sel, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic idleCycles(input int n, input bit randReady);
        for (int i = 0; i < n; i++) begin
            if (randReady) dr8 = 1'($urandom_range(0, 1));
            @(posedge iClock);
            #1;
        end
    endtask

    task automatic applyReset();
        iReset = 1'b1;
        @(posedge iClock);
        @(posedge iClock);
        #1;
        iReset = 1'b0;
        clearModels();
    endtask

    // Scoreboard side: one word is consumed per cycle with valid & ready.
    always @(negedge iClock) begin
        word_t e;
        if (!iReset && ov2 && dr2) begin
            check("u2_word_expected", 64'(q2.size() != 0), 64'd1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                check("u2_data", 64'(od2), e.data);
                check("u2_last", 64'(ol2), 64'(e.last));
`ifdef DEC_UPSIZE_KEEP_EN
                check("u2_keep", 64'(ok2), 64'(e.keep));
`endif
            end
        end
    end

    always @(negedge iClock) begin
        word_t e;
        if (!iReset && ov4 && dr4) begin
            check("u4_word_expected", 64'(q4.size() != 0), 64'd1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                check("u4_data", od4, e.data);
                check("u4_last", 64'(ol4), 64'(e.last));
`ifdef DEC_UPSIZE_KEEP_EN
                check("u4_keep", 64'(ok4), 64'(e.keep));
`endif
            end
        end
    end

    always @(negedge iClock) begin
        word_t e;
        if (!iReset && ov8 && dr8) begin
            words8++;
            check("u8_word_expected", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("u8_data", od8, e.data);
                check("u8_last", 64'(ol8), 64'(e.last));
`ifdef DEC_UPSIZE_KEEP_EN
                check("u8_keep", 64'(ok8), 64'(e.keep));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iReset = 1'b1;
        for (int s = 0; s < 3; s++) driveSrc(s, 1'b0, 16'h0, 1'b0);
        dr2 = 1'b1;
        dr4 = 1'b1;
        dr8 = 1'b1;
        clearModels();
        applyReset();

        // Reset state
        check("rst_ready2", 64'(r2), 64'd1);
        check("rst_valid2", 64'(ov2), 64'd0);
        check("rst_data2", 64'(od2), 64'd0);
        check("rst_last2", 64'(ol2), 64'd0);
        check("rst_ready4", 64'(r4), 64'd1);
        check("rst_valid4", 64'(ov4), 64'd0);
        check("rst_ready8", 64'(r8), 64'd1);
        check("rst_data8", od8, 64'd0);
`ifdef DEC_UPSIZE_KEEP_EN
        check("rst_keep4", 64'(ok4), 64'd0);
`endif

        // Test 1: two beats, last on the second
        sendBeat(0, 16'h1111, 1'b0, 1'b0, stalls);
        check("t1_valid_early", 64'(ov2), 64'd0);
        sendBeat(0, 16'h2222, 1'b1, 1'b0, stalls);
        check("t1_valid", 64'(ov2), 64'd1);
        check("t1_data", 64'(od2), 64'h11112222);
        check("t1_last", 64'(ol2), 64'd1);
        idleCycles(2, 1'b0);
        check("t1_drained", 64'(ov2), 64'd0);
        check("t1_queue_empty", 64'(q2.size()), 64'd0);

        // Test 2: eight back-to-back beats into RATIO=4
        for (int i = 0; i < 8; i++) begin
            sendBeat(1, 16'(32'h1000 + i), 1'b0, 1'b0, stalls);
            check("t2_no_stall", 64'(stalls), 64'd0);
            check("t2_valid_pulse", 64'(ov4), 64'((i % 4) == 3));
        end
        idleCycles(2, 1'b0);
        check("t2_queue_empty", 64'(q4.size()), 64'd0);

        // Test 3: last on the second beat -> partial word, low lanes zero
        sendBeat(1, 16'hAAAA, 1'b0, 1'b0, stalls);
        sendBeat(1, 16'hBBBB, 1'b1, 1'b0, stalls);
        check("t3_valid", 64'(ov4), 64'd1);
        check("t3_data", od4, 64'hAAAABBBB00000000);
        check("t3_last", 64'(ol4), 64'd1);
`ifdef DEC_UPSIZE_KEEP_EN
        check("t3_keep", 64'(ok4), 64'b1100);
`endif
        idleCycles(2, 1'b0);

        // Test 4: downstream stalled while two words are offered
        dr4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sendBeat(1, 16'(32'hC000 + i), 1'b0, 1'b0, stalls);
            check("t4_no_stall", 64'(stalls), 64'd0);
        end
        check("t4_ready_hold", 64'(r4), 64'd0);
        check("t4_valid", 64'(ov4), 64'd1);
        check("t4_data_first", od4, 64'hC000C001C002C003);
        idleCycles(3, 1'b0);
        check("t4_data_stable", od4, 64'hC000C001C002C003);
        check("t4_still_hold", 64'(r4), 64'd0);
        dr4 = 1'b1;
        @(posedge iClock);
        #1;
        check("t4_valid2", 64'(ov4), 64'd1);
        check("t4_data_second", od4, 64'hC004C005C006C007);
        check("t4_ready_back", 64'(r4), 64'd1);
        idleCycles(2, 1'b0);
        check("t4_drained", 64'(ov4), 64'd0);
        check("t4_queue_empty", 64'(q4.size()), 64'd0);

        // Test 5: reset after one of two beats discards the partial word
        sendBeat(0, 16'h5555, 1'b0, 1'b0, stalls);
        applyReset();
        check("t5_ready", 64'(r2), 64'd1);
        check("t5_valid", 64'(ov2), 64'd0);
        idleCycles(3, 1'b0);
        check("t5_no_word", 64'(ov2), 64'd0);
        sendBeat(0, 16'h3333, 1'b0, 1'b0, stalls);
        sendBeat(0, 16'h4444, 1'b0, 1'b0, stalls);
        check("t5_valid_after", 64'(ov2), 64'd1);
        check("t5_data", 64'(od2), 64'h33334444);
        check("t5_last", 64'(ol2), 64'd0);
        idleCycles(2, 1'b0);
        check("t5_queue_empty", 64'(q2.size()), 64'd0);

        // Test 6: random valid gaps, random ready, random last on 8x8
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 3)), 1'b1);
            sendBeat(2, 16'($urandom_range(0, 255)), 1'($urandom_range(0, 9) == 0), 1'b1, stalls);
        end
        dr8 = 1'b1;
        idleCycles(20, 1'b0);
        check("t6_queue_empty", 64'(q8.size()), 64'd0);
        check("t6_word_count", 64'(words8), 64'(pushed8));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
